// File: rtl/genesys_axi_rd_arbiter.sv
// Shares one AXI4 read master among NUM_REQ buffer read engines with an in-order R ownership FIFO.
// Optional macro GENESYS_RD_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module genesys_axi_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  output logic [NUM_REQ-1:0]            req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]          req_arlen,
  output logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          req_rlast,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic                          m_axi_rlast,
  output logic                          busy
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int PTRW = $clog2(MAX_OUTSTANDING);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                r_state;
  logic [IDXW-1:0]       r_grant;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [IDXW-1:0]       r_fifo [MAX_OUTSTANDING];
  logic [PTRW-1:0]       r_wptr;
  logic [PTRW-1:0]       r_rptr;
  logic [CNTW-1:0]       r_count;
`ifndef GENESYS_RD_ARB_FIXED_PRIO_EN
  logic [IDXW-1:0]       r_last_grant;
`endif

  logic                  w_any_req;
  logic                  w_grant_ok;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [IDXW-1:0]       w_grant_idx;
  logic [IDXW-1:0]       w_head;
  logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
  logic [7:0]            w_len_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = req_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_len_arr[gi]  = req_arlen[gi*8 +: 8];
  end

`ifdef GENESYS_RD_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest asserted index is the last one written.
  always_comb begin
    w_any_req   = 1'b0;
    w_grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_arvalid[i]) begin
        w_any_req   = 1'b1;
        w_grant_idx = IDXW'(i);
      end
    end
  end
`else
  // Scan offsets from farthest to nearest after last_grant; the nearest requester wins.
  always_comb begin : rr_grant
    int idx;
    w_any_req   = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(r_last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_arvalid[IDXW'(idx)]) begin
        w_any_req   = 1'b1;
        w_grant_idx = IDXW'(idx);
      end
    end
  end
`endif

  assign w_empty    = (r_count == '0);
  assign w_head     = r_fifo[r_rptr];
  assign w_grant_ok = (r_state == S_IDLE) && w_any_req && (r_count < MAX_CNT);
  assign w_push     = (r_state == S_ISSUE) && m_axi_arready;
  assign w_pop      = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  assign req_arready   = w_grant_ok ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign req_rvalid    = (m_axi_rvalid && !w_empty) ? (NUM_REQ'(1) << w_head) : '0;
  assign m_axi_rready  = !w_empty && req_rready[w_head];
  assign req_rdata     = m_axi_rdata;
  assign req_rlast     = m_axi_rlast;
  assign m_axi_arvalid = (r_state == S_ISSUE);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign busy          = (r_state == S_ISSUE) || !w_empty;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
`ifndef GENESYS_RD_ARB_FIXED_PRIO_EN
      r_last_grant <= IDXW'(NUM_REQ - 1);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_ok) begin
            r_state      <= S_ISSUE;
            r_grant      <= w_grant_idx;
            r_araddr     <= w_addr_arr[w_grant_idx];
            r_arlen      <= w_len_arr[w_grant_idx];
`ifndef GENESYS_RD_ARB_FIXED_PRIO_EN
            r_last_grant <= w_grant_idx;
`endif
          end
        end
        S_ISSUE: begin
          if (m_axi_arready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) r_wptr <= r_wptr + PTRW'(1);
      if (w_pop)  r_rptr <= r_rptr + PTRW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNTW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNTW'(1);
    end
  end

  // Ownership storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge ap_clk) begin
    if (w_push) r_fifo[r_wptr] <= r_grant;
  end

endmodule
